// File: rtl/vector_pkg.sv
// vector_pkg: opcode and FSM state enums plus default widths shared by the vector execute stage.
package vector_pkg;
    localparam int VEC_ELEM_W   = 8;
    localparam int VEC_NUM_ELEM = 24;
    localparam int SCALAR_W     = 21;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDS, OP_MUL, OP_REDSUM
    } vsa_op_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} vsa_state_e;
endpackage

// File: rtl/vsa_lane_alu.sv
// vsa_lane_alu: combinational single-element ALU.
// Arithmetic clamps when VSA_SATURATE_EN is defined, otherwise wraps modulo 2^ELEM_W.
module vsa_lane_alu import vector_pkg::*; #(
    parameter int ELEM_W = VEC_ELEM_W
) (
    input  vsa_op_e           op,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic [ELEM_W-1:0] scalar,
    output logic [ELEM_W-1:0] y
);
    logic [ELEM_W-1:0] addend, add_r, sub_r, mul_r;
    assign addend = (op == OP_ADDS) ? scalar : b;
`ifdef VSA_SATURATE_EN
    logic [ELEM_W:0]     sum;
    logic [2*ELEM_W-1:0] prod;
    assign sum   = {1'b0, a} + {1'b0, addend};
    assign prod  = {{ELEM_W{1'b0}}, a} * {{ELEM_W{1'b0}}, b};
    assign add_r = sum[ELEM_W] ? '1 : sum[ELEM_W-1:0];
    assign sub_r = (a < b) ? '0 : a - b;
    assign mul_r = |prod[2*ELEM_W-1:ELEM_W] ? '1 : prod[ELEM_W-1:0];
`else
    assign add_r = a + addend;
    assign sub_r = a - b;
    assign mul_r = a * b;
`endif
    // REDSUM produces no vector result
    always_comb begin
        case (op)
            OP_ADD, OP_ADDS: y = add_r;
            OP_SUB:          y = sub_r;
            OP_AND:          y = a & b;
            OP_OR:           y = a | b;
            OP_XOR:          y = a ^ b;
            OP_MUL:          y = mul_r;
            default:         y = '0;
        endcase
    end
endmodule

// File: rtl/vector_stream_alu.sv
// vector_stream_alu: multi-beat vector ALU, LANES elements per cycle, result held under valid/ready.
// Define VSA_SATURATE_EN for clamping arithmetic and reduction instead of wrap-around.
module vector_stream_alu import vector_pkg::*; #(
    parameter int ELEM_W   = VEC_ELEM_W,
    parameter int NUM_ELEM = VEC_NUM_ELEM,
    parameter int LANES    = 4,
    parameter int SCALAR_W = vector_pkg::SCALAR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [NUM_ELEM*ELEM_W-1:0] in_va,
    input  logic [NUM_ELEM*ELEM_W-1:0] in_vb,
    input  logic [SCALAR_W-1:0]        in_scalar,
    input  logic [3:0]                 in_dest,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_ELEM*ELEM_W-1:0] out_vec,
    output logic [SCALAR_W-1:0]        out_redsum,
    output logic [3:0]                 out_dest,
    output logic                       busy
);
    localparam int BEATS = NUM_ELEM / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = LANES * ELEM_W;
    localparam int VW    = NUM_ELEM * ELEM_W;
    localparam int TW    = ELEM_W + $clog2(LANES + 1);

    vsa_state_e          state, state_nx;
    vsa_op_e             op_r;
    logic [VW-1:0]       va_r, vb_r;
    logic [ELEM_W-1:0]   scalar_r;
    logic [CW-1:0]       beat;
    logic [SCALAR_W-1:0] acc, acc_nx;
    logic [LW-1:0]       cur_a, cur_b, lane_y;
    logic [TW-1:0]       tree;
    logic                accept, last_beat;

    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_beat  = beat == CW'(BEATS - 1);
    assign out_valid  = state == DONE;
    assign busy       = state != IDLE;
    assign out_redsum = acc;
    assign cur_a      = va_r[int'(beat) * LW +: LW];
    assign cur_b      = vb_r[int'(beat) * LW +: LW];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vsa_lane_alu #(.ELEM_W(ELEM_W)) u_alu (
            .op     (op_r),
            .a      (cur_a[i*ELEM_W +: ELEM_W]),
            .b      (cur_b[i*ELEM_W +: ELEM_W]),
            .scalar (scalar_r),
            .y      (lane_y[i*ELEM_W +: ELEM_W])
        );
    end

    always_comb begin
        tree = '0;
        for (int j = 0; j < LANES; j++) tree = tree + TW'(cur_a[j*ELEM_W +: ELEM_W]);
    end

`ifdef VSA_SATURATE_EN
    localparam int SW = ((SCALAR_W > TW) ? SCALAR_W : TW) + 1;
    logic [SW-1:0] acc_sum;
    assign acc_sum = SW'(acc) + SW'(tree);
    assign acc_nx  = (acc_sum > SW'({SCALAR_W{1'b1}})) ? '1 : acc_sum[SCALAR_W-1:0];
`else
    assign acc_nx = acc + SCALAR_W'(tree);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // DONE with out_ready and a pending input skips IDLE entirely
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last_beat) state_nx = DONE;
            DONE:    if (out_ready) state_nx = in_valid ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= OP_ADD;
            va_r     <= '0;
            vb_r     <= '0;
            scalar_r <= '0;
            out_dest <= '0;
            beat     <= '0;
            acc      <= '0;
            out_vec  <= '0;
        end else if (accept) begin
            op_r     <= vsa_op_e'(in_op);
            va_r     <= in_va;
            vb_r     <= in_vb;
            scalar_r <= ELEM_W'(in_scalar);
            out_dest <= in_dest;
            beat     <= '0;
            acc      <= '0;
        end else if (state == RUN) begin
            out_vec[int'(beat) * LW +: LW] <= lane_y;
            if (op_r == OP_REDSUM) acc <= acc_nx;
            beat <= last_beat ? '0 : beat + CW'(1);
        end
    end
endmodule

// File: doc/vector_stream_alu.md
# vector_stream_alu

Parametrised multi-beat vector ALU for the vector pipeline's execute stage. It accepts one vector instruction per handshake, latches the operands, and processes `LANES` elements per cycle over `NUM_ELEM/LANES` beats. It then holds the result under a valid/ready handshake toward the MEM stage. It generalises the fixed 192-bit single-cycle vector execute path in three ways: configurable element width, element count and lane count; scalar-broadcast ops; and a reduction op.

## Interface
Parameters:
- `ELEM_W`, 8: element width in bits
- `NUM_ELEM`, 24: elements per vector; must be a multiple of `LANES`
- `LANES`, 4: elements processed per cycle
- `SCALAR_W`, 21: scalar operand and reduction result width

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  block can accept
- `in_op`  in  3  opcode, `vsa_op_e`
- `in_va`  in  `NUM_ELEM*ELEM_W`  vector A; element 0 at LSBs
- `in_vb`  in  `NUM_ELEM*ELEM_W`  vector B
- `in_scalar`  in  `SCALAR_W`  scalar operand
- `in_dest`  in  4  destination register tag
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer accepts
- `out_vec`  out  `NUM_ELEM*ELEM_W`  vector result
- `out_redsum`  out  `SCALAR_W`  reduction result
- `out_dest`  out  4  tag of the result
- `busy`  out  1  state is not IDLE

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (a−b)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 ADDS (a + scalar; scalar truncated to its low `ELEM_W` bits, broadcast)
  - 6 MUL (low `ELEM_W` bits of a×b)
  - 7 REDSUM (sum of all elements of a)
- All elements are unsigned. Arithmetic wraps modulo 2^`ELEM_W` unless `VSA_SATURATE_EN` is defined.
- REDSUM: elements are zero-extended and accumulated modulo 2^`SCALAR_W`. `out_vec` = 0.
- For non-REDSUM ops `out_redsum` = 0.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid` the block latches op, va, vb, scalar and dest; clears the beat counter and accumulator; goes to RUN.
  - RUN: one beat per cycle. Beat k writes elements k·`LANES` … k·`LANES`+`LANES`−1 and adds them to the accumulator. After beat `BEATS`−1 the state goes to DONE.
  - DONE: `out_valid`=1. `out_vec`, `out_redsum` and `out_dest` are stable until `out_ready`.
- Leaving DONE:
  - `out_ready`=1 and `in_valid`=0: go to IDLE.
  - `out_ready`=1 and `in_valid`=1: accept the new instruction in the same cycle and go directly to RUN. `in_ready` = IDLE or (DONE and `out_ready`), which is combinational.
- Input during RUN or DONE without `out_ready` is not accepted (`in_ready`=0). Offered inputs must be held by the producer.
- Reset values: state IDLE, `out_valid` 0, `out_vec` 0, `out_redsum` 0, `out_dest` 0, `busy` 0, `in_ready` 1, beat counter 0, accumulator 0.
- Reset mid-RUN or in DONE aborts the instruction immediately (asynchronous). No partial result is ever presented.

## Timing
- `BEATS` = `NUM_ELEM/LANES` (6 at defaults).
- Accept at edge T0. Beats complete on edges T1…T`BEATS`. `out_valid` rises after edge T`BEATS`, so latency is `BEATS` cycles.
- Throughput with `out_ready` tied high: one instruction per `BEATS`+1 cycles. The DONE cycle overlaps the next acceptance.
- `out_vec` element slices update only in the beat that computes them. The full vector is guaranteed only when `out_valid`=1.
- `busy` is registered state; it is 1 in RUN and DONE.

## Configuration
- `VSA_SATURATE_EN` defined: these ops clamp instead of wrapping.
  - ADD and ADDS clamp to 2^`ELEM_W`−1.
  - SUB clamps to 0.
  - MUL clamps to 2^`ELEM_W`−1 when the full product overflows.
  - REDSUM clamps to 2^`SCALAR_W`−1.
- Undefined: all results wrap modulo the result width. No saturation logic is generated.

## Structure
- Package `vector_pkg` holds:
  - `vsa_op_e` enum
  - FSM state enum `vsa_state_e` (IDLE, RUN, DONE)
  - default width constants (`VEC_ELEM_W`=8, `VEC_NUM_ELEM`=24, `SCALAR_W`=21)
- Sub-module `vsa_lane_alu`: combinational single-element ALU (op, a, b, scalar → `ELEM_W` result). The saturation variant is selected by the macro. It is instantiated `LANES` times by generate.
- The top holds the FSM, beat counter (`$clog2(BEATS)` bits), operand and result registers, and the reduction accumulator plus an adder tree over `LANES` elements.

## Test plan
- ADD, va all 0x10, vb all 0x05, `out_ready`=1: `out_vec` all 0x15. `out_valid` is 1 exactly 6 cycles after acceptance. `out_redsum`=0.
- ADD 0xF0+0x20 and SUB 0x05−0x09:
  - without macro: 0x10 and 0xFC
  - with `VSA_SATURATE_EN`: 0xFF and 0x00
- REDSUM with element i = i (0…23): `out_redsum`=276, `out_vec`=0. ADDS with scalar 0x1_0003: every element = a+0x03.
- Hold `out_ready`=0 for 5 cycles in DONE: `out_valid`, `out_vec` and `out_dest` stay stable; `in_ready`=0. Then raise `out_ready` with `in_valid`=1: the new op is accepted in the same cycle and its result appears 6 cycles later.
- Assert `rst_n`=0 during beat 3: `out_valid`, `busy`, `out_vec` and `out_dest` go to 0 and `in_ready` goes to 1 without a clock edge. The next instruction completes normally.
- Parameter sweep (`ELEM_W`=16, `NUM_ELEM`=12, `LANES`=12): `BEATS`=1, latency 1 cycle. MUL 0x0100×0x0100 = 0x0000 without the macro and 0xFFFF with it.
